sobel_window_ctrl: RTL

- Streaming controller that sequences the combinational Sobel kernel (8-neighbour inputs p0..p3, p5..p8; 8-bit edge result) over a raster image.
- Accepts one pixel per cycle with a valid/ready handshake and stores the two previous rows in line buffers.
- Presents the 3x3 neighbourhood to the kernel, registers the kernel result, and emits one output per interior pixel with backpressure.
- Sits between the frame-source stream and the edge-map sink.

---
 rtl/sobel_pkg.sv | 17 +
 rtl/sobel_window_ctrl_if.sv | 22 ++
 rtl/sobel_line_buf.sv | 22 ++
 rtl/sobel_window_ctrl.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// rtl/sobel_pkg.sv - shared constants, FSM states and index-width helper for the Sobel window controller
package sobel_pkg;

    localparam int PIX_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sobel_window_ctrl_if.sv
// rtl/sobel_window_ctrl_if.sv - pixel-in / edge-out stream bundle for the Sobel window controller
interface sobel_window_ctrl_if #(
    parameter int PW = sobel_pkg::PIX_W
);
    logic          in_valid;
    logic [PW-1:0] in_pix;
    logic          in_ready;
    logic          out_valid;
    logic [PW-1:0] out_pix;
    logic          out_last;
    logic          out_ready;

    modport master (
        output in_valid, in_pix, out_ready,
        input  in_ready, out_valid, out_pix, out_last
    );

    modport slave (
        input  in_valid, in_pix, out_ready,
        output in_ready, out_valid, out_pix, out_last
    );
endinterface

// File: rtl/sobel_line_buf.sv
// rtl/sobel_line_buf.sv - one image row of pixels, synchronous write and asynchronous read at one address
module sobel_line_buf #(
    parameter int DEPTH = 64,
    parameter int AW    = 6,
    parameter int PW    = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [PW-1:0] wdata,
    output logic [PW-1:0] rdata
);
    logic [PW-1:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];
endmodule

// File: rtl/sobel_window_ctrl.sv
// rtl/sobel_window_ctrl.sv - raster-scan 3x3 window sequencer feeding an external Sobel kernel
module sobel_window_ctrl
    import sobel_pkg::*;
#(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64,
    parameter int PW    = PIX_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    sobel_window_ctrl_if.slave  s,
    output logic [PW-1:0]       k_p0,
    output logic [PW-1:0]       k_p1,
    output logic [PW-1:0]       k_p2,
    output logic [PW-1:0]       k_p3,
    output logic [PW-1:0]       k_p5,
    output logic [PW-1:0]       k_p6,
    output logic [PW-1:0]       k_p7,
    output logic [PW-1:0]       k_p8,
    input  logic [PW-1:0]       k_out,
    output logic                busy,
    output logic                done
);
    localparam int XW = idx_w(IMG_W);
    localparam int YW = idx_w(IMG_H);
    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
    localparam logic [XW-1:0] X_TWO  = XW'(2);
    localparam logic [YW-1:0] Y_TWO  = YW'(2);

    state_t        state, state_n;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          win_valid;
    logic          win_last;
    logic [PW-1:0] win [0:8];
    logic [PW-1:0] lb0_rd;
    logic [PW-1:0] lb1_rd;
    logic          s2_free;
    logic          accept;
    logic          s2_load;
    logic          row_end;
    logic          frame_end;

    assign s2_free    = !s.out_valid || s.out_ready;
    assign s.in_ready = (state == RUN) && (!win_valid || s2_free);
    assign accept     = s.in_valid && s.in_ready;
    assign s2_load    = win_valid && s2_free;
    assign row_end    = (x == X_LAST);
    assign frame_end  = row_end && (y == Y_LAST);

    // lb0 holds the previous row, lb1 the row before that
    sobel_line_buf #(.DEPTH(IMG_W), .AW(XW), .PW(PW)) u_lb0 (
        .clk   (clk),
        .we    (accept),
        .addr  (x),
        .wdata (s.in_pix),
        .rdata (lb0_rd)
    );

    sobel_line_buf #(.DEPTH(IMG_W), .AW(XW), .PW(PW)) u_lb1 (
        .clk   (clk),
        .we    (accept),
        .addr  (x),
        .wdata (lb0_rd),
        .rdata (lb1_rd)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        busy    = 1'b1;
        done    = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_n = RUN;
            end
            RUN: begin
                if (accept && frame_end) state_n = DRAIN;
            end
            DRAIN: begin
                if (!win_valid && !s.out_valid) state_n = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x           <= '0;
            y           <= '0;
            win_valid   <= 1'b0;
            win_last    <= 1'b0;
            s.out_valid <= 1'b0;
            s.out_pix   <= '0;
            s.out_last  <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                win[i] <= '0;
            end
        end else begin
            if (state == IDLE && start) begin
                x <= '0;
                y <= '0;
            end else if (accept) begin
                if (row_end) begin
                    x <= '0;
                    y <= frame_end ? '0 : y + 1'b1;
                end else begin
                    x <= x + 1'b1;
                end
            end

            // Columns left over from the previous row are flushed out by x<2 before any emit
            if (accept) begin
                win[0]    <= win[1];
                win[1]    <= win[2];
                win[2]    <= lb1_rd;
                win[3]    <= win[4];
                win[4]    <= win[5];
                win[5]    <= lb0_rd;
                win[6]    <= win[7];
                win[7]    <= win[8];
                win[8]    <= s.in_pix;
                win_valid <= (y >= Y_TWO) && (x >= X_TWO);
                win_last  <= frame_end;
            end else if (s2_load) begin
                win_valid <= 1'b0;
            end

            if (s2_load) begin
                s.out_pix   <= k_out;
                s.out_valid <= 1'b1;
                s.out_last  <= win_last;
            end else if (s.out_valid && s.out_ready) begin
                s.out_valid <= 1'b0;
                s.out_last  <= 1'b0;
            end
        end
    end

    assign k_p0 = win[0];
    assign k_p1 = win[1];
    assign k_p2 = win[2];
    assign k_p3 = win[3];
    assign k_p5 = win[5];
    assign k_p6 = win[6];
    assign k_p7 = win[7];
    assign k_p8 = win[8];
endmodule
